input_port_controller: RTL

INPUT_PORT_CONTROLLER -- requirements
Module: input_port_controller

---
 rtl/input_port_controller_pkg.sv | 28 ++
 rtl/input_port_controller_flit_fifo.sv | 49 ++++
 rtl/input_port_controller.sv | 109 ++++++++++
 3 files changed

// File: rtl/input_port_controller_pkg.sv
// Shared NoC definitions: flit-type codes and input-port FSM encodings,
// also used by the head-flit decoder and the switch allocator.
package input_port_controller_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ROUTE   = 2'b01,
        S_FORWARD = 2'b10
    } ipc_state_e;

    localparam int FLIT_TYPE_W = 2;

    function automatic logic starts_packet(input flit_type_e t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    function automatic logic ends_packet(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/input_port_controller_flit_fifo.sv
// Circular flit buffer; front reads as zero when empty.
module flit_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] front
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign front = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers are AW bits wide, so increments wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/input_port_controller.sv
// NoC router input port: buffers flits, latches the head-flit route,
// requests the switch and streams the packet to the crossbar.
module input_port_controller
    import input_port_controller_pkg::*;
#(
    parameter int N             = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int PhitPerFlit   = 2,
    parameter int REQUEST_WIDTH = 2,
    parameter int FIFO_DEPTH    = 4,
    localparam int FLIT_WIDTH   = PhitPerFlit * DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_WIDTH-1:0]    data_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic [FLIT_WIDTH-1:0]    head_flit,
    input  logic [REQUEST_WIDTH-1:0] request_message,
    output logic [REQUEST_WIDTH-1:0] route_req,
    output logic                     req_valid,
    input  logic                     grant,
    output logic [FLIT_WIDTH-1:0]    data_out,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic                     error
);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if ((1 << REQUEST_WIDTH) < N) begin : g_chk_req
        $error("REQUEST_WIDTH too narrow to address N ports");
    end

    ipc_state_e               state_q, state_d;
    logic [REQUEST_WIDTH-1:0] route_q, route_d;
    logic                     full, empty, push, pop;
    logic [FLIT_WIDTH-1:0]    front;
    flit_type_e               front_type;

    // Full blocks the write even when a pop frees a slot in the same cycle.
    assign ready_in   = !full;
    assign push       = valid_in && ready_in;
    assign head_flit  = front;
    assign data_out   = front;
    assign route_req  = route_q;
    assign front_type = flit_type_e'(front[FLIT_WIDTH-1 -: FLIT_TYPE_W]);

    flit_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (data_in),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .front (front)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        pop       = 1'b0;
        error     = 1'b0;
        req_valid = 1'b0;
        valid_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (starts_packet(front_type)) begin
                        route_d = request_message;
                        state_d = S_ROUTE;
                    end else begin
                        // Orphan body/tail with no head: drop it and flag.
                        pop   = 1'b1;
                        error = 1'b1;
                    end
                end
            end
            S_ROUTE: begin
                req_valid = 1'b1;
                if (grant) state_d = S_FORWARD;
            end
            S_FORWARD: begin
                req_valid = 1'b1;
                valid_out = !empty;
                if (valid_out && ready_out) begin
                    pop = 1'b1;
                    if (ends_packet(front_type)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
